// File: rtl/matmul_engine_pkg.sv
// Shared state encoding and width helpers for the matrix-multiply datapath.
package matmul_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'b00,
    COMPUTE = 2'b01,
    DONE    = 2'b11
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_w(input int n);
    return idx_w(n * n);
  endfunction

  // Load counter must reach 2*N*N itself so that it saturates rather than wraps.
  function automatic int cnt_w(input int n);
    return $clog2(2 * n * n + 1);
  endfunction

  function automatic int acc_w(input int data_w, input int n);
    return 2 * data_w + $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_engine_if.sv
// Grant, element-stream and read-port bundle between the matmul controller and matmul_engine.
interface matmul_engine_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int RES_W  = 20
);

  logic                              g1;
  logic                              g2;
  logic                              g3;
  logic                              load_valid;
  logic [DATA_W-1:0]                 load_data;
  logic [matmul_pkg::addr_w(N)-1:0]  rd_addr;
  logic                              process_ready;
  logic                              process_finish;
  logic [RES_W-1:0]                  rd_data;
  logic                              overflow;

  modport master (
    output g1, g2, g3, load_valid, load_data, rd_addr,
    input  process_ready, process_finish, rd_data, overflow
  );

  modport slave (
    input  g1, g2, g3, load_valid, load_data, rd_addr,
    output process_ready, process_finish, rd_data, overflow
  );

endinterface

// File: rtl/matmul_engine_mac.sv
// Registered multiply-accumulate; clear empties the accumulator after its final term.
// Defining MATMUL_ENGINE_SATURATE_EN clamps res to RES_W bits instead of truncating.
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 20,
  parameter int ACC_W  = 18
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clear,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [RES_W-1:0]  res,
  output logic              sat
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum;

  always_comb begin
    sum   = acc_q + ACC_W'(a) * ACC_W'(b);
    acc_d = acc_q;
    if (en) begin
      acc_d = clear ? '0 : sum;
    end
  end

  always_comb begin
`ifdef MATMUL_ENGINE_SATURATE_EN
    sat = ((sum >> RES_W) != '0);
    res = sat ? {RES_W{1'b1}} : RES_W'(sum);
`else
    sat = 1'b0;
    res = RES_W'(sum);
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// Matrix-multiply datapath: loads A and B, runs N^3 MAC cycles, then serves C on a read port.
// Result saturation is enabled by defining MATMUL_ENGINE_SATURATE_EN (handled in mac_unit).
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int RES_W  = 20
) (
  input  logic           clock,
  input  logic           reset_n,
  matmul_engine_if.slave bus
);

  localparam int IW    = idx_w(N);
  localparam int AW    = addr_w(N);
  localparam int CW    = cnt_w(N);
  localparam int ACC_W = acc_w(DATA_W, N);

  localparam logic [CW-1:0] NN_C     = CW'(N * N);
  localparam logic [CW-1:0] LOAD_MAX = CW'(2 * N * N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [AW:0]   NN_A     = (AW + 1)'(N * N);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
  logic              ready_q, ready_d;
  logic              finish_q, finish_d;
  logic              overflow_q, overflow_d;
  logic [RES_W-1:0]  rd_data_q, rd_data_d;

  logic [DATA_W-1:0] a_mem [N*N];
  logic [DATA_W-1:0] b_mem [N*N];
  logic [RES_W-1:0]  c_mem [N*N];

  logic              load_we;
  logic              mac_en;
  logic              mac_last;
  logic [AW-1:0]     a_idx, b_idx, c_idx;
  logic [RES_W-1:0]  mac_res;
  logic              mac_sat;

  assign a_idx = AW'(int'(i_q) * N + int'(k_q));
  assign b_idx = AW'(int'(k_q) * N + int'(j_q));
  assign c_idx = AW'(int'(i_q) * N + int'(j_q));

  mac_unit #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (mac_en),
    .clear   (mac_last),
    .a       (a_mem[a_idx]),
    .b       (b_mem[b_idx]),
    .res     (mac_res),
    .sat     (mac_sat)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    ready_d    = ready_q;
    finish_d   = finish_q;
    overflow_d = overflow_q;
    rd_data_d  = '0;
    load_we    = 1'b0;
    mac_en     = 1'b0;
    mac_last   = 1'b0;

    unique case (state_q)
      LOAD: begin
        // Starting the compute takes priority over a load offered on the same cycle.
        if (ready_q && bus.g2) begin
          state_d = COMPUTE;
        end else if (bus.load_valid && bus.g1 && (cnt_q < LOAD_MAX)) begin
          load_we = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LOAD_MAX - CW'(1)) begin
            ready_d = 1'b1;
          end
        end
      end
      COMPUTE: begin
        mac_en   = 1'b1;
        mac_last = (k_q == LAST_IDX);
        k_d      = mac_last ? '0 : k_q + IW'(1);
        if (mac_last) begin
          overflow_d = overflow_q | mac_sat;
          j_d        = (j_q == LAST_IDX) ? '0 : j_q + IW'(1);
          if (j_q == LAST_IDX) begin
            i_d = (i_q == LAST_IDX) ? '0 : i_q + IW'(1);
            if (i_q == LAST_IDX) begin
              finish_d = 1'b1;
              state_d  = DONE;
            end
          end
        end
      end
      DONE: begin
        if (bus.g3 && ({1'b0, bus.rd_addr} < NN_A)) begin
          rd_data_d = c_mem[bus.rd_addr];
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      ready_q    <= 1'b0;
      finish_q   <= 1'b0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      ready_q    <= ready_d;
      finish_q   <= finish_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Matrix storage is deliberately not reset; only writes are suppressed while in reset.
  always_ff @(posedge clock) begin
    if (reset_n && load_we) begin
      if (cnt_q < NN_C) begin
        a_mem[AW'(cnt_q)] <= bus.load_data;
      end else begin
        b_mem[AW'(cnt_q - NN_C)] <= bus.load_data;
      end
    end
    if (reset_n && mac_last) begin
      c_mem[c_idx] <= mac_res;
    end
  end

  assign bus.process_ready  = ready_q;
  assign bus.process_finish = finish_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.overflow       = overflow_q;

endmodule
